// File: rtl/ascon_pkg.sv
// Shared ASCON sequencing types and round-count constants.
// Imported by the permutation control and core blocks.
package ascon_pkg;

  localparam int ASCON_PA_ROUNDS = 12;
  localparam int ASCON_PB_ROUNDS = 6;
  localparam int ASCON_IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ascon_round_ctrl.sv
// ASCON p^a round sequencer: walks the round-constant index
// MAX_ROUNDS-a .. MAX_ROUNDS-1 and pulses done / err.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start_i      : permutation request (taken only when ready_o)
//   rounds_i     : round count a, sampled with an accepted start
//   stall_i      : freezes the round sequence
//   abort_i      : cancels a permutation in progress
//   ready_o      : idle
//   busy_o       : running or finishing
//   round_en_o   : datapath applies a round this cycle
//   const_idx_o  : round-constant index
//   first_o      : current round is the first one
//   last_o       : current round is the final one
//   done_o       : one-cycle pulse after the final round
//   err_o        : one-cycle pulse on a rejected start
module ascon_round_ctrl
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = ASCON_PA_ROUNDS,
  parameter int IDX_W      = ASCON_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [4:0]       rounds_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             round_en_o,
  output logic [IDX_W-1:0] const_idx_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [4:0]       MAX_R    = 5'(MAX_ROUNDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_ROUNDS - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] end_idx;
  logic             done_q;
  logic             err_q;
  logic             run;
  logic             req_ok;

  assign run    = (state == RUN);
  assign req_ok = (rounds_i != 5'd0) && (rounds_i <= MAX_R);

  assign ready_o     = (state == IDLE);
  assign busy_o      = (state == RUN) || (state == DONE);
  assign round_en_o  = run && !stall_i && !abort_i;
  assign first_o     = run && (idx == start_idx);
  assign last_o      = run && (idx == end_idx);
  assign const_idx_o = idx;
  assign done_o      = done_q;
  assign err_o       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      start_idx <= '0;
      end_idx   <= LAST_IDX;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (req_ok) begin
              idx       <= IDX_W'(MAX_R - rounds_i);
              start_idx <= IDX_W'(MAX_R - rounds_i);
              end_idx   <= LAST_IDX;
              state     <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // abort beats stall; the final round ends in DONE
          if (abort_i) begin
            state <= IDLE;
            idx   <= '0;
          end else if (!stall_i) begin
            if (idx == end_idx) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: rounds-left model
// checked every cycle, plus directed literal scenarios.
module tb_ascon_round_ctrl;

  localparam int MAXR = 12;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] rounds;
  logic       stall;
  logic       abort;
  logic       ready_o;
  logic       busy_o;
  logic       round_en_o;
  logic [3:0] const_idx_o;
  logic       first_o;
  logic       last_o;
  logic       done_o;
  logic       err_o;

  int checks = 0;
  int failures = 0;

  ascon_round_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .rounds_i(rounds),
    .stall_i(stall),
    .abort_i(abort),
    .ready_o(ready_o),
    .busy_o(busy_o),
    .round_en_o(round_en_o),
    .const_idx_o(const_idx_o),
    .first_o(first_o),
    .last_o(last_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int rc(input int i);
    return ((15 - i) << 4) | i;
  endfunction

  // model: rounds still to apply, total a, finishing flag, err flag
  int m_left;
  int m_a;
  bit m_fin;
  bit m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_a    <= 0;
      m_fin  <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_fin) begin
        m_fin <= 1'b0;
      end else if (m_left > 0) begin
        if (abort) begin
          m_left <= 0;
        end else if (!stall) begin
          if (m_left == 1) m_fin <= 1'b1;
          m_left <= m_left - 1;
        end
      end else if (start) begin
        if (rounds >= 1 && rounds <= MAXR) begin
          m_left <= int'(rounds);
          m_a    <= int'(rounds);
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit run;
    int eidx;
    run  = (m_left > 0);
    eidx = run ? MAXR - m_left : (m_fin ? MAXR - 1 : 0);
    chk("ready", ready_o, int'(!run && !m_fin));
    chk("busy", busy_o, int'(run || m_fin));
    chk("round_en", round_en_o, int'(run && !stall && !abort));
    chk("idx", const_idx_o, eidx);
    chk("first", first_o, int'(run && m_left == m_a));
    chk("last", last_o, int'(run && m_left == 1));
    chk("done", done_o, int'(m_fin));
    chk("err", err_o, int'(m_err));
  end

  int ens, dcyc, rcyc, ridx, ecyc, errs;
  int fidx, fcnt, lidx, lcnt;
  logic [31:0] bz;

  task automatic launch(input int r);
    @(posedge clk);
    #1;
    start  = 1'b1;
    rounds = 5'(r);
    stall  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic observe(input int n, input int st_idx,
                         input int st_n, input int ab_idx,
                         input int rs_idx, input bit hold);
    int sl;
    sl = st_n;
    ens = 0; dcyc = -1; rcyc = -1; ridx = -1; ecyc = -1;
    errs = 0; fidx = -1; fcnt = 0; lidx = -1; lcnt = 0;
    bz = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      start = hold;
      stall = 1'b0;
      abort = 1'b0;
      if (busy_o && !done_o) begin
        if (int'(const_idx_o) == st_idx && sl > 0) begin
          stall = 1'b1;
          sl--;
        end
        if (int'(const_idx_o) == ab_idx) begin
          abort  = 1'b1;
          stall  = 1'b1;
          ab_idx = -1;
        end
        if (int'(const_idx_o) == rs_idx) begin
          rst_n = 1'b0;
          #1;
          chk("async_ready", ready_o, 1);
          chk("async_busy", busy_o, 0);
          chk("async_en", round_en_o, 0);
          chk("async_idx", const_idx_o, 0);
          chk("async_last", last_o, 0);
          rst_n  = 1'b1;
          rs_idx = -1;
        end
      end
      @(negedge clk);
      if (round_en_o) ens++;
      if (done_o && dcyc < 0) dcyc = k;
      if (ready_o && rcyc < 0) begin
        rcyc = k;
        ridx = int'(const_idx_o);
      end
      if (err_o) begin
        errs++;
        if (ecyc < 0) ecyc = k;
      end
      if (first_o) begin
        fcnt++;
        fidx = int'(const_idx_o);
      end
      if (last_o) begin
        lcnt++;
        lidx = int'(const_idx_o);
      end
      if (k < 32) bz[k] = busy_o;
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    @(posedge clk);
    #1;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) break;
    end
    chk("wait_idle", ready_o, 1);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    rounds = 5'd0;
    stall  = 1'b0;
    abort  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_idx", const_idx_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    launch(12);
    observe(16, -1, 0, -1, -1, 1'b0);
    chk("a12_ens", ens, 12);
    chk("a12_first_idx", fidx, 0);
    chk("a12_first_cnt", fcnt, 1);
    chk("a12_last_idx", lidx, 11);
    chk("a12_done_cyc", dcyc, 13);
    chk("a12_ready_cyc", rcyc, 14);
    chk("a12_rc_first", rc(fidx), 'hf0);
    chk("a12_rc_last", rc(lidx), 'h4b);
    wait_idle();

    launch(6);
    observe(10, -1, 0, -1, -1, 1'b0);
    chk("a6_ens", ens, 6);
    chk("a6_first_idx", fidx, 6);
    chk("a6_first_cnt", fcnt, 1);
    chk("a6_rc_first", rc(fidx), 'h96);
    chk("a6_done_cyc", dcyc, 7);
    wait_idle();

    launch(8);
    observe(14, 5, 3, -1, -1, 1'b0);
    chk("a8s_ens", ens, 8);
    chk("a8s_first_idx", fidx, 4);
    chk("a8s_done_cyc", dcyc, 12);
    wait_idle();

    launch(1);
    observe(4, -1, 0, -1, -1, 1'b0);
    chk("a1_ens", ens, 1);
    chk("a1_first_idx", fidx, 11);
    chk("a1_last_idx", lidx, 11);
    chk("a1_last_cnt", lcnt, 1);
    chk("a1_done_cyc", dcyc, 2);
    wait_idle();

    launch(0);
    observe(3, -1, 0, -1, -1, 1'b0);
    chk("r0_errs", errs, 1);
    chk("r0_err_cyc", ecyc, 1);
    chk("r0_ens", ens, 0);
    chk("r0_ready_cyc", rcyc, 1);
    wait_idle();

    launch(13);
    observe(3, -1, 0, -1, -1, 1'b0);
    chk("r13_errs", errs, 1);
    chk("r13_ens", ens, 0);
    chk("r13_ready_cyc", rcyc, 1);
    wait_idle();

    launch(12);
    observe(8, -1, 0, 3, -1, 1'b0);
    chk("abort_ens", ens, 3);
    chk("abort_done", dcyc, -1);
    chk("abort_ready_cyc", rcyc, 5);
    chk("abort_idx", ridx, 0);
    wait_idle();

    launch(12);
    observe(16, -1, 0, -1, 7, 1'b0);
    chk("reset_ens", ens, 7);
    chk("reset_done", dcyc, -1);
    chk("reset_ready_cyc", rcyc, 8);
    wait_idle();

    launch(12);
    observe(16, -1, 0, -1, -1, 1'b1);
    chk("hold_errs", errs, 0);
    chk("hold_done_cyc", dcyc, 13);
    chk("hold_ready_cyc", rcyc, 14);
    chk("hold_busy15", int'(bz[15]), 1);
    wait_idle();

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n  = ($urandom_range(0, 499) != 0);
      start  = ($urandom_range(0, 3) == 0);
      rounds = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) rounds = 5'($urandom_range(1, 12));
      stall  = ($urandom_range(0, 4) == 0);
      abort  = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_round_ctrl.md
Name: ascon_round_ctrl

Overview:
Sequencer for the ASCON permutation round datapath. It accepts a permutation request for p^a, where a is 1..MAX_ROUNDS (12 for p^a, 6 or 8 for p^b). It then steps the 4-bit round-constant index from MAX_ROUNDS-a up to MAX_ROUNDS-1, one round per un-stalled cycle. Its outputs drive the round-constant lookup and the round-enable, first-round and last-round strobes of the permutation core, and it signals completion to the mode FSM.

Parameters:
MAX_ROUNDS, 12, rounds of the full permutation; legal range 1..15.
IDX_W, 4, width of the constant-index output; must satisfy 2^IDX_W >= MAX_ROUNDS.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start_i  in  1  request a permutation; accepted only when ready_o=1.
rounds_i  in  5  round count a, sampled with an accepted start_i.
stall_i  in  1  datapath hold; freezes the round sequence.
abort_i  in  1  cancel the permutation in progress.
ready_o  out  1  controller idle; high only in IDLE.
busy_o  out  1  high in RUN or DONE.
round_en_o  out  1  datapath applies one round this cycle.
const_idx_o  out  IDX_W  round-constant index for the current round.
first_o  out  1  current round is the first round of the permutation.
last_o  out  1  current round is the final round of the permutation.
done_o  out  1  one-cycle pulse after the final round.
err_o  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset values (asynchronous, when rst_n=0): state=IDLE; const_idx_o=0; done_o=0; err_o=0; ready_o=1; busy_o=0; round_en_o=0; first_o=0; last_o=0.
- States: IDLE, RUN, DONE.
- IDLE, start_i=1 with 1<=rounds_i<=MAX_ROUNDS:
  - const_idx_o <= MAX_ROUNDS-rounds_i;
  - end index register <= MAX_ROUNDS-1;
  - state -> RUN.
- IDLE, start_i=1 with rounds_i=0 or rounds_i>MAX_ROUNDS: err_o=1 for exactly the next cycle; state stays IDLE; const_idx_o unchanged.
- Start in RUN or DONE: ignored; no error is raised.
- RUN outputs (combinational):
  - round_en_o = !stall_i && !abort_i;
  - first_o = (const_idx_o == start index);
  - last_o = (const_idx_o == MAX_ROUNDS-1).
  - first_o and last_o are valid whenever in RUN; both are high together when rounds_i=1.
- RUN transitions, in priority order:
  - abort_i=1: -> IDLE; no done_o; const_idx_o <= 0. Abort wins over stall.
  - stall_i=1: hold state and index.
  - last round (last_o=1): -> DONE.
  - otherwise: const_idx_o <= const_idx_o+1.
- The index never wraps: the maximum value reached is MAX_ROUNDS-1.
- DONE: done_o=1 (registered, one cycle); const_idx_o <= 0; -> IDLE. abort_i and stall_i are ignored in DONE.
- Latency with no stalls: start accepted at edge T; rounds applied in cycles T+1..T+a; done_o during T+a+1; ready_o=1 again from T+a+2. Each stalled cycle adds one cycle.
- abort_i in IDLE: no effect.
- Reset asserted mid-RUN: immediate return to reset values; no done_o is produced.

Decomposition:
- Package ascon_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constants ASCON_PA_ROUNDS=12, ASCON_PB_ROUNDS=6, ASCON_IDX_W=4.
- No sub-module is required. The round-constant lookup stays outside and is fed by const_idx_o at the permutation core level.
- The index/end-compare logic may be written inline; a separate counter module is not warranted.

Test Plan:
- rounds_i=12 start: round_en_o for 12 cycles; const_idx_o 0..11, mapping to constants 0xf0,0xe1,...,0x4b; first_o at idx 0; last_o at idx 11; done_o at T+13; ready_o at T+14.
- rounds_i=6 start: const_idx_o 6..11 (constants 0x96..0x4b); done_o at T+7; first_o at idx 6 only.
- rounds_i=8 with stall_i held for 3 cycles during idx 5: idx sequence 4,5,5,5,5,6..11; round_en_o low during the 3 stalled cycles; done_o at T+12.
- rounds_i=1 start: a single cycle with first_o=last_o=round_en_o=1 and idx 11; done_o at T+2.
- rounds_i=0 and rounds_i=13: each gives err_o pulse=1 for one cycle; ready_o stays 1; no round_en_o.
- rounds_i=12 with abort_i at idx 3 (stall_i also high): IDLE next cycle, no done_o, const_idx_o=0.
- rounds_i=12 with rst_n pulsed low at idx 7: all outputs return to reset values asynchronously; no done_o.
- start_i held high throughout the rounds_i=12 case: the second start is accepted only at T+14; no err_o is raised.
